fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// - Instruction-fetch stage driving the PC register: consumes current PC, issues one
//   instruction-memory read at a time, and generates that register's next value and write enable.
// - Buffers returned instructions in a small queue toward decode; branch/jump redirects from
//   EX flush the queue and discard any in-flight read.
// PARAMETERS
// - DEPTH    2   instruction queue entries (power of 2, >=2)
// - ADDR_W   32  address/PC width
// - INSTR_W  32  instruction width
// PORTS
// - clk             in   1        single clock, rising edge
// - reset           in   1        synchronous, active-high
// - pc_in           in   ADDR_W   current PC (PC register output)
// - pc_next         out  ADDR_W   next PC (PC register input)
// - pcwrite         out  1        PC register write enable
// - redirect_valid  in   1        branch/jump taken, from EX
// - redirect_pc     in   ADDR_W   redirect target
// - imem_req        out  1        read request, held until imem_ack
// - imem_addr       out  ADDR_W   read address, stable while imem_req
// - imem_ack        in   1        read complete, imem_rdata valid this cycle
// - imem_rdata      in   INSTR_W  instruction data
// - id_valid        out  1        queue head valid
// - id_instr        out  INSTR_W  head instruction
// - id_pc           out  ADDR_W   head instruction address
// - id_pc4          out  ADDR_W   head address + 4
// - id_ready        in   1        decode accepts head (pop when id_valid&&id_ready)
// BEHAVIOUR
// - Reset (sync): state IDLE, queue empty, imem_req=0, imem_addr=0, id_valid=0; pcwrite=0 during reset.
// - States: IDLE (no read outstanding), REQ (read outstanding, data kept), DROP (read outstanding, data discarded).
// - imem_req = (state!=IDLE); imem_addr registered, loaded from pc_in on IDLE->REQ and on REQ->REQ.
// - Space check: free = DEPTH - count (+1 if pop this cycle); issue only when free >= 1 after pending push.
// - IDLE: !redirect && space -> REQ; else stay.
// - REQ, imem_ack && !redirect: push {imem_rdata, imem_addr, imem_addr+4}; pcwrite=1, pc_next=pc_in+4;
//   stay REQ (new addr = pc_in+4) if space remains after push/pop, else IDLE. One read per ack, back-to-back.
// - REQ, !imem_ack && redirect: -> DROP; imem_req/imem_addr held.
// - REQ, imem_ack && redirect: data discarded, -> IDLE.
// - DROP: imem_ack -> IDLE, data discarded; never pushes.
// - Redirect (any state): pcwrite=1, pc_next={redirect_pc[ADDR_W-1:2],2'b00}; queue flushed at edge;
//   same-cycle pop is void; id_valid=0 next cycle. Redirect beats ack-driven PC update.
// - No redirect and no accepted ack: pcwrite=0, pc_next=pc_in+4 (don't-care).
// - Arithmetic: +4 modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
// - Latency: ack at cycle N -> id_valid at N+1 (if queue was empty).
// - Full: no issue; push+pop same cycle when full is legal (count unchanged).
// - Empty: pop ignored. Queue pointers wrap modulo DEPTH.
// - Reset mid-read: state -> IDLE; any later ack while IDLE ignored.
// STRUCTURE
// - Shared package fetch_pkg: state encoding (IDLE/REQ/DROP), INSTR_W, ADDR_W, PC_INC=4.
// - Sub-module fetch_queue: synchronous FIFO (DEPTH, width INSTR_W+2*ADDR_W) with push, pop, flush,
//   count, empty/full; flush overrides push and pop.
// - Top: FSM, imem_addr register, next-PC mux.
// TESTING
// - Reset, pc_in=0, imem_ack one cycle after each req, id_ready=1 -> reads at 0x0,0x4,0x8; id_pc
//   matches; pcwrite once per ack.
// - id_ready=0, DEPTH=2 -> exactly 2 reads issued, imem_req low afterwards; id_ready=1 -> fetch resumes at 0x8.
// - Redirect to 0x40 with read to 0x10 outstanding (no ack) -> DROP; ack 3 cycles later discarded;
//   next read at 0x40; queue empty.
// - Redirect to 0x80 in same cycle as ack for 0x10 -> 0x10 not pushed; pc_next=0x80; next read at 0x80.
// - Redirect to 0x103 -> pc_next=0x100; pc_in=0xFFFFFFFC, ack -> pc_next=0x00000000, id_pc4=0x0.
// - Assert reset during REQ, ack arrives after reset -> ignored; id_valid=0; fresh read at current pc_in.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  // IDLE: nothing outstanding; REQ: read outstanding, data will be kept;
  // DROP: read outstanding, data will be thrown away when it lands.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // One queued instruction with its address and fall-through address.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc4;
  } fetch_entry_t;

  localparam int ENTRY_W = INSTR_W + 2 * ADDR_W;

  // Sequential next address; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_plus_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_INC);
  endfunction

  // Clear the byte-offset bits so redirect targets are word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(PC_INC - 1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port and decode-facing instruction stream.
// Latency: n/a (wires only).
// Backpressure: imem_req held until imem_ack; id_valid held until id_ready.
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic [ADDR_W-1:0]  id_pc4;
  logic               id_ready;

  // Fetch-unit side.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output id_valid, id_instr, id_pc, id_pc4,
    input  id_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  id_valid, id_instr, id_pc, id_pc4,
    output id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched instructions toward decode.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees a slot; flush beats push and pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap modulo DEPTH through their width.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, next-PC generation, queue toward decode.
// Latency: imem_ack in cycle N gives id_valid in N+1 when the queue was empty.
// Backpressure: no new read unless a queue slot is guaranteed; redirect flushes and drops in-flight data.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pcwrite,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;

  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  q_count;
  logic              q_empty;
  logic              q_full;
  logic [CNT_W:0]    occ_after;
  logic              space;
  fetch_entry_t      push_ent;
  fetch_entry_t      head_ent;

  // A redirect voids the same-cycle pop and discards any returning data.
  assign pop  = !q_empty && bus.id_ready && !redirect_valid;
  assign push = (state == REQ) && bus.imem_ack && !redirect_valid;

  // Occupancy once this cycle's push/pop land; a new read needs one free slot
  // left over so its data can never find the queue full.
  assign occ_after = {1'b0, q_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign space     = q_full ? (pop && !push) : (occ_after < (CNT_W+1)'(DEPTH));

  assign push_ent.instr = bus.imem_rdata;
  assign push_ent.pc    = addr_q;
  assign push_ent.pc4   = pc_plus_inc(addr_q);

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_dat (head_ent),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign bus.id_valid  = !q_empty;
  assign bus.id_instr  = head_ent.instr;
  assign bus.id_pc     = head_ent.pc;
  assign bus.id_pc4    = head_ent.pc4;
  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = addr_q;

  // State and read-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Next-state logic; the read address only moves when a new read is issued.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    case (state)
      IDLE: begin
        if (!redirect_valid && space) begin
          state_nxt = REQ;
          addr_nxt  = pc_in;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (!redirect_valid && space) begin
            state_nxt = REQ;
            addr_nxt  = pc_plus_inc(pc_in);
          end else begin
            state_nxt = IDLE;
          end
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next-PC mux: redirect wins over the sequential update from an accepted read.
  always_comb begin
    pcwrite = 1'b0;
    pc_next = pc_plus_inc(pc_in);
    if (reset) begin
      pcwrite = 1'b0;
    end else if (redirect_valid) begin
      pcwrite = 1'b1;
      pc_next = word_align(redirect_pc);
    end else if (push) begin
      pcwrite = 1'b1;
    end
  end

endmodule
